// File: rtl/k2_loader_pkg.sv
// k2_loader_pkg: shared types and constants for the K2 program loader.
//   loader_state_t : loader FSM encoding (IDLE, LOAD, CHECK, RUN, ERROR)
//   ADDR_BITS      : default program address width (depth = 2**ADDR_BITS)
//   INSTR_BITS     : default instruction / stream byte width
//   LAST_ADDR      : highest program address for the default geometry
package k2_loader_pkg;

  localparam int ADDR_BITS  = 4;
  localparam int INSTR_BITS = 8;
  localparam int LAST_ADDR  = (1 << ADDR_BITS) - 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    RUN,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/k2_prog_mem.sv
// k2_prog_mem: program store, 2**AddrBits words of InstrBits each.
//   clk, rst : clock and asynchronous active-high clear of every word
//   we       : write enable, waddr/wdata written on the rising edge
//   raddr    : asynchronous read address
//   rdata    : word at raddr, combinational
module k2_prog_mem
  import k2_loader_pkg::*;
#(
  parameter int AddrBits  = ADDR_BITS,
  parameter int InstrBits = INSTR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [AddrBits-1:0]  waddr,
  input  logic [InstrBits-1:0] wdata,
  input  logic [AddrBits-1:0]  raddr,
  output logic [InstrBits-1:0] rdata
);

  localparam int Depth = 1 << AddrBits;

  logic [InstrBits-1:0] mem [Depth];

  // NOTE: the array is cleared on reset because a freshly reset loader must
  // read back all-zero words; this forces flops rather than a RAM macro,
  // which is acceptable at this depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else if (we) begin
      // NOTE: non-blocking assignment so every reader in this edge sees the
      // pre-edge value of the array.
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/k2_program_loader.sv
// k2_program_loader: loads a 16-byte program plus checksum from a
// valid/ready byte stream and serves it to the K2 processor.
//   clk, rst          : clock, asynchronous active-high reset
//   load_req          : one-cycle pulse, start or restart a load
//   in_valid/in_data  : stream byte, accepted when in_ready is high
//   in_ready          : high in LOAD and CHECK only (state-only decode)
//   ProgramAddress    : processor fetch address
//   instruction_data  : mem[ProgramAddress] in RUN, otherwise 0
//   cpu_rst_n         : processor reset, high only in RUN (registered)
//   load_done         : one-cycle pulse on entry to RUN (registered)
//   load_error        : sticky checksum-mismatch flag
module k2_program_loader
  import k2_loader_pkg::*;
#(
  parameter int AddrBits  = ADDR_BITS,
  parameter int InstrBits = INSTR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_req,
  input  logic                 in_valid,
  input  logic [InstrBits-1:0] in_data,
  output logic                 in_ready,
  input  logic [AddrBits-1:0]  ProgramAddress,
  output logic [InstrBits-1:0] instruction_data,
  output logic                 cpu_rst_n,
  output logic                 load_done,
  output logic                 load_error
);

  localparam logic [AddrBits-1:0] LastAddr = AddrBits'((1 << AddrBits) - 1);

  loader_state_t        state, next_state;
  logic [AddrBits-1:0]  count;
  logic [InstrBits-1:0] sum;
  logic [InstrBits-1:0] rdata;
  logic                 handshake;
  logic                 mem_we;

  assign in_ready  = (state == LOAD) || (state == CHECK);
  assign handshake = in_valid && in_ready;

  // NOTE: every variable is given a default before the case statement so no
  // path through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    next_state = state;
    mem_we     = 1'b0;
    if (load_req) begin
      // A restart wins over everything; a coincident byte is dropped.
      next_state = LOAD;
    end else begin
      case (state)
        LOAD: begin
          if (handshake) begin
            mem_we = 1'b1;
            if (count == LastAddr) next_state = CHECK;
          end
        end
        CHECK: begin
          if (handshake) next_state = (in_data == sum) ? RUN : ERROR;
        end
        default: next_state = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      sum        <= '0;
      cpu_rst_n  <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state <= next_state;
      if (load_req) begin
        count <= '0;
        sum   <= '0;
      end else if (mem_we) begin
        count <= count + 1'b1;
        sum   <= sum + in_data;
      end
      // Registered from the next-state decode so both outputs are glitch-free
      // and change on the very edge that enters or leaves RUN.
      cpu_rst_n <= (next_state == RUN);
      load_done <= (state == CHECK) && (next_state == RUN);
      if (load_req) begin
        load_error <= 1'b0;
      end else if ((state == CHECK) && (next_state == ERROR)) begin
        load_error <= 1'b1;
      end
    end
  end

  k2_prog_mem #(
    .AddrBits  (AddrBits),
    .InstrBits (InstrBits)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (count),
    .wdata (in_data),
    .raddr (ProgramAddress),
    .rdata (rdata)
  );

  assign instruction_data = (state == RUN) ? rdata : '0;

endmodule
